water_led_top: RTL and testbench

// - Board-level running-light ("water LED") generator: one-hot walk across 8 LEDs plus colour cycling on four RGB LEDs.
// - Top of the LED demo; single clock domain, no handshakes; drives LED pins directly.
// - Bench clock is 50 MHz (20 ns period); step timing comes from a prescaler so simulation can shorten it.

---
 rtl/water_led_top.sv | 118 +++++++++++
 tb/tb_water_led_top.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/water_led_top.sv
// Running-light LED demo: one-hot walk over 8 LEDs plus colour cycling on four RGB LEDs.
// Define WATER_LED_BOUNCE_EN for ping-pong walking instead of rotate-left with wrap.
module water_led_top #(
  parameter int STEP_CYCLES = 25_000_000,
  parameter int CNT_W       = 25
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] led,
  output logic [2:0] ld1,
  output logic [2:0] ld2,
  output logic [2:0] ld3,
  output logic [2:0] ld4
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_s;
  logic [7:0]       led_q, led_d;
  logic [2:0]       c_q, c_d;
  logic [2:0]       ld1_q, ld2_q, ld3_q, ld4_q;
`ifdef WATER_LED_BOUNCE_EN
  logic             dir_q, dir_d;
`endif

  // Colour for RGB LED at offset off from index c, staying inside 1..7.
  function automatic logic [2:0] col_map(input logic [2:0] c, input logic [2:0] off);
    logic [3:0] s;
    s = {1'b0, c} + {1'b0, off};
    if (s > 4'd7) begin
      s = s - 4'd7;
    end else begin
      s = s;
    end
    return s[2:0];
  endfunction

  // Prescaler: one tick per STEP_CYCLES clocks.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_s = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Next LED position and colour index; colour moves when the walk returns to LED 0.
  always_comb begin
    led_d = led_q;
    c_d   = c_q;
`ifdef WATER_LED_BOUNCE_EN
    dir_d = dir_q;
`endif
    if (tick_s) begin
`ifdef WATER_LED_BOUNCE_EN
      if (dir_q) begin
        led_d = {1'b0, led_q[7:1]};
      end else begin
        led_d = {led_q[6:0], 1'b0};
      end
      if (led_d == 8'h80) begin
        dir_d = 1'b1;
      end else if (led_d == 8'h01) begin
        dir_d = 1'b0;
      end else begin
        dir_d = dir_q;
      end
`else
      led_d = {led_q[6:0], led_q[7]};
`endif
      if (led_d == 8'h01) begin
        c_d = (c_q == 3'd7) ? 3'd1 : (c_q + 3'd1);
      end else begin
        c_d = c_q;
      end
    end else begin
      led_d = led_q;
    end
  end

  // State and registered outputs; RGB values follow c in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      led_q <= 8'h01;
      c_q   <= 3'd1;
      ld1_q <= 3'b001;
      ld2_q <= 3'b010;
      ld3_q <= 3'b011;
      ld4_q <= 3'b100;
`ifdef WATER_LED_BOUNCE_EN
      dir_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
      c_q   <= c_d;
      ld1_q <= col_map(c_d, 3'd0);
      ld2_q <= col_map(c_d, 3'd1);
      ld3_q <= col_map(c_d, 3'd2);
      ld4_q <= col_map(c_d, 3'd3);
`ifdef WATER_LED_BOUNCE_EN
      dir_q <= dir_d;
`endif
    end
  end

  assign led = led_q;
  assign ld1 = ld1_q;
  assign ld2 = ld2_q;
  assign ld3 = ld3_q;
  assign ld4 = ld4_q;

endmodule

// File: tb/tb_water_led_top.sv
// Self-checking bench for water_led_top with a short prescaler; reference model
// derives LED position and colour from the number of clocks since reset.
module tb_water_led_top;

  localparam int STEP = 4;

  logic       clk;
  logic       rst;
  logic [7:0] led;
  logic [2:0] ld1, ld2, ld3, ld4;
  logic [2:0] ld_a [4];

  int checks;
  int errors;
  int n;

  water_led_top #(.STEP_CYCLES(STEP), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .led(led), .ld1(ld1), .ld2(ld2), .ld3(ld3), .ld4(ld4)
  );

  assign ld_a[0] = ld1;
  assign ld_a[1] = ld2;
  assign ld_a[2] = ld3;
  assign ld_a[3] = ld4;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference: position and colour computed from step count since reset.
  function automatic logic [7:0] exp_led(input int cyc);
    int s, p, pos;
    s = cyc / STEP;
`ifdef WATER_LED_BOUNCE_EN
    p   = s % 14;
    pos = (p <= 7) ? p : 14 - p;
`else
    p   = s % 8;
    pos = p;
`endif
    return 8'h01 << pos;
  endfunction

  function automatic int exp_c(input int cyc);
    int s;
    s = cyc / STEP;
`ifdef WATER_LED_BOUNCE_EN
    return ((s / 14) % 7) + 1;
`else
    return ((s / 8) % 7) + 1;
`endif
  endfunction

  function automatic logic [2:0] exp_ld(input int cyc, input int k);
    return 3'(((exp_c(cyc) - 1 + k) % 7) + 1);
  endfunction

  // Advance one clock; n counts non-reset edges since the last reset edge.
  task automatic step_clk();
    @(posedge clk);
    if (rst) n = 0;
    else n = n + 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step_clk();
    checks++;
    if (led !== 8'h01) begin
      errors++;
      $display("FAIL reset_led got %h exp 01", led);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ld_a[k] !== 3'(k + 1)) begin
        errors++;
        $display("FAIL reset_ld%0d got %0d exp %0d", k + 1, ld_a[k], k + 1);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int         tgt [5];
    logic [7:0] eled [5];
    logic [2:0] eld1 [5];
`ifdef WATER_LED_BOUNCE_EN
    tgt  = '{4, 28, 32, 52, 56};
    eled = '{8'h02, 8'h80, 8'h40, 8'h02, 8'h01};
    eld1 = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
`else
    tgt  = '{4, 28, 32, 60, 224};
    eled = '{8'h02, 8'h80, 8'h01, 8'h80, 8'h01};
    eld1 = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1};
`endif
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      while (n < tgt[i]) step_clk();
      checks++;
      if (led !== eled[i]) begin
        errors++;
        $display("FAIL directed_led n=%0d got %h exp %h", n, led, eled[i]);
      end
      checks++;
      if (ld1 !== eld1[i]) begin
        errors++;
        $display("FAIL directed_ld1 n=%0d got %0d exp %0d", n, ld1, eld1[i]);
      end
    end
  endtask

  task automatic test_random_walk(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst = ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0;
      step_clk();
      checks++;
      if (led !== exp_led(n)) begin
        errors++;
        $display("FAIL walk_led n=%0d got %h exp %h", n, led, exp_led(n));
      end
      checks++;
      if (!$onehot(led)) begin
        errors++;
        $display("FAIL walk_onehot n=%0d got %h exp one-hot", n, led);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ld_a[k] !== exp_ld(n, k) || ld_a[k] === 3'b000) begin
          errors++;
          $display("FAIL walk_ld%0d n=%0d got %0d exp %0d", k + 1, n, ld_a[k], exp_ld(n, k));
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_midstep_reset(input int iters);
    int phase, budget;
    for (int it = 0; it < iters; it++) begin
      phase  = $urandom_range(1, STEP - 1);
      budget = 0;
      while (!(exp_led(n) == 8'h10 && (n % STEP) == phase) && budget < 400) begin
        step_clk();
        budget++;
      end
      checks++;
      if (budget >= 400 || led !== 8'h10) begin
        errors++;
        $display("FAIL midreset_reach got %h exp 10 within budget", led);
      end
      rst = 1'b1;
      step_clk();
      rst = 1'b0;
      checks++;
      if (led !== 8'h01 || ld1 !== 3'd1) begin
        errors++;
        $display("FAIL midreset_state got led %h ld1 %0d exp 01/1", led, ld1);
      end
      repeat (STEP - 1) step_clk();
      checks++;
      if (led !== 8'h01) begin
        errors++;
        $display("FAIL midreset_early got %h exp 01", led);
      end
      step_clk();
      checks++;
      if (led !== 8'h02) begin
        errors++;
        $display("FAIL midreset_step got %h exp 02", led);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n      = 0;
    rst    = 1'b1;
    test_reset();
    test_directed();
    test_random_walk(int'($urandom_range(400, 700)));
    test_midstep_reset(6);
    test_random_walk(300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
